mem_access_unit: RTL

Load/store unit sitting between the MEM pipeline stage and the byte-addressed, little-endian data memory. It turns byte, halfword and word loads/stores into word-aligned memory transactions. Sub-word stores use read-modify-write. Sub-word loads get lane extraction plus sign or zero extension. It also checks alignment and range, and returns a single-cycle response pulse to the pipeline.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: turns byte/half/word accesses into word memory ops.
// Ports: req_* from MEM stage, resp_* back, mem_* to data memory.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] MEM_LIM = 32'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] merge_q;
  logic        err_q;

  logic        req_err;
  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] merge_v;

  // Priority order is irrelevant for a single error bit.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)
      req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (req_addr >= MEM_LIM)
      req_err = 1'b1;
  end

  assign lane   = addr_q[1:0];
  assign byte_v = mem_read_data[{lane, 3'b000} +: 8];
  assign half_v = mem_read_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_v = mem_read_data;
    case (size_q)
      2'b00: load_v = {{24{sgn_q & byte_v[7]}}, byte_v};
      2'b01: load_v = {{16{sgn_q & half_v[15]}}, half_v};
      default: load_v = mem_read_data;
    endcase
  end

  always_comb begin
    merge_v = mem_read_data;
    if (size_q == 2'b00)
      merge_v[{lane, 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_v[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            req_err:
              state_d = S_RESP;
            (req_write && req_size == 2'b10):
              state_d = S_WRITE;
            default:
              state_d = S_READ;
          endcase
        end
      end
      S_READ:  state_d = S_HOLD;
      S_HOLD:  state_d = wr_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state_q == S_HOLD) begin
        if (wr_q)
          merge_q <= merge_v;
        else
          rdata_q <= load_v;
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_err    = (state_q == S_RESP) && err_q;
  assign resp_rdata  = (state_q == S_RESP) ? rdata_q : '0;
  assign mem_read    = (state_q == S_READ);
  assign mem_write   = (state_q == S_WRITE);
  assign mem_address =
    (state_q == S_IDLE) ? '0 : {addr_q[31:2], 2'b00};
  assign mem_write_data =
    (state_q != S_WRITE) ? '0 :
    (size_q == 2'b10)    ? wdata_q : merge_q;

endmodule
